map_row_writer: RTL and testbench
=================================

Name: map_row_writer

Overview:
- Producer side of the map-block array: procedurally generates map rows ahead of the ball and writes them, one block per handshake, into the map store that the ball logic reads back.
- Keeps the map filled LOOKAHEAD rows ahead of the ball's current row, using the store as a ring of ROWS rows.
- Every row contains a continuous, walkable safe column, so each generated row is passable.

Parameters:
COLS, 5, columns per row (1..8; wr_x is 3 bits)
ROWS, 2048, ring depth in rows; wr_y = head_row mod ROWS (power of two, ≤2048)
LOOKAHEAD, 32, maximum rows generated ahead of ball_row (must be < ROWS)
INIT_SAFE, 8, rows after start written entirely as state 1
GAP_THRESH, 4, non-safe cell is empty when LFSR nibble < GAP_THRESH
SEED, 16'hACE1, LFSR reset value (0 is replaced by 16'h0001)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins generation from row 0
ball_row  in  16  absolute row index currently under the ball
wr_en  out  1  write request valid
wr_x  out  3  column index of block being written
wr_y  out  11  ring row index of block being written
wr_data  out  3  block state: 0 empty, 1 normal, 2 bounce
wr_ready  in  1  map store accepts the write this cycle
head_row  out  16  absolute index of the next row to generate
busy  out  1  high while in any state other than IDLE/WAIT

Behaviour:
- Reset (rst=0, async): state IDLE. wr_en=0, wr_x=0, wr_y=0, wr_data=0, head_row=0, busy=0. Internal safe_col=COLS/2, LFSR=SEED. A reset during WRITE abandons the partial row; no further wr_en is issued.
- Transfer occurs on a rising edge with wr_en=1 and wr_ready=1. While wr_en=1 and wr_ready=0, wr_x, wr_y and wr_data hold stable. wr_en never drops without a transfer.
- Fill condition: diff = head_row - ball_row (16-bit wrap).
  - need = diff[15] | (diff < LOOKAHEAD).
  - A ball ahead of head (negative diff) therefore forces generation.
- States:
  - IDLE: wait for start; start=1 -> PLAN. start in any other state is ignored.
  - WAIT: busy=0. need=1 -> PLAN; else stay.
  - PLAN (1 cycle):
    - If head_row < INIT_SAFE, the row pattern is all 1.
    - Otherwise:
      - Step safe_col using LFSR[1:0]: 00 means -1, 01 means +1, otherwise hold. Clamp to 0..COLS-1.
      - Non-safe cells are resolved in WRITE.
    - Set wr_x=0 -> WRITE.
  - WRITE:
    - Present cell (wr_x, wr_y=head_row[10:0] masked to ROWS).
    - wr_data rules:
      - Safe column or initial row: 1.
      - Otherwise, with nibble=LFSR[3:0]: 0 if nibble<GAP_THRESH, 2 if nibble==15, else 1.
    - On transfer:
      - LFSR steps once.
      - If wr_x==COLS-1 -> ADVANCE; else wr_x+1.
  - ADVANCE (1 cycle):
    - head_row+1 (wraps 16'hFFFF -> 0).
    - LFSR steps once; wr_en=0.
    - need -> PLAN, else WAIT.
- LFSR: 16-bit Galois, shift right, XOR 16'hB400 when the shifted-out bit is 1. It steps only on a transfer or in ADVANCE, so the generated sequence is independent of wr_ready stalls.
- Throughput: COLS+2 cycles per row when wr_ready=1 constantly.
- Latency: the first wr_en rises 2 cycles after the start pulse edge.
- Legal values: only 0, 1, 2 are ever written. The safe column cell is never 0.
- Ring overwrite safety: a row is written only when need=1, so slot head_row mod ROWS is never within LOOKAHEAD rows at or ahead of ball_row.
- ball_row may change on any cycle; it is sampled only in WAIT/ADVANCE.

Test Plan:
- Reset, then start with ball_row=0 and wr_ready=1 -> first wr_en 2 cycles after start; rows 0..7 all wr_data=1. Writes stop with head_row=32; busy=0 in WAIT.
- From the steady state, advance ball_row 0->1 -> exactly one row (5 writes, wr_y=32) is generated, then head_row=33.
- Toggle wr_ready randomly 0/1 -> outputs hold while stalled. The written data stream is bit-identical to the wr_ready=1 run with the same SEED.
- Run 4096 rows -> every row has ≥1 nonzero cell. The safe column differs by ≤1 between consecutive rows. wr_data is never in 3..7. wr_y wraps 2047->0.
- Assert rst low mid-WRITE (wr_x=2) -> wr_en=0 and head_row=0 immediately (async). Pulse start again -> the sequence restarts identically from row 0.
- Set ball_row=100 while head_row=40 -> continuous generation without WAIT until head_row=132.

Source files
------------

// File: rtl/map_row_writer.sv
// ---------------------------------------------------------------------------
// map_row_writer
//
// Producer side of the map-block array. Procedurally generates map rows ahead
// of the ball and writes them, one block per valid/ready handshake, into the
// map store. The store is a ring of ROWS rows and is kept filled up to
// LOOKAHEAD rows ahead of the ball's current row. Each generated row carries a
// continuous, walkable safe column that moves by at most one column per row,
// so every row is passable.
//
// Ports:
//   clk       in   1   system clock
//   rst       in   1   asynchronous, active-low reset
//   start     in   1   one-cycle pulse; begins generation from row 0 (IDLE only)
//   ball_row  in  16   absolute row index currently under the ball
//   wr_en     out  1   write request valid
//   wr_x      out  3   column index of the block being written
//   wr_y      out 11   ring row index of the block being written
//   wr_data   out  3   block state: 0 empty, 1 normal, 2 bounce
//   wr_ready  in   1   map store accepts the write this cycle
//   head_row  out 16   absolute index of the next row to generate
//   busy      out  1   high while in PLAN, WRITE or ADVANCE
//
// A transfer happens on a rising edge with wr_en=1 and wr_ready=1. The LFSR
// only advances on a transfer or in ADVANCE, so the generated map does not
// depend on how the store stalls the writer.
// ---------------------------------------------------------------------------
module map_row_writer #(
    parameter int          COLS       = 5,
    parameter int          ROWS       = 2048,
    parameter int          LOOKAHEAD  = 32,
    parameter int          INIT_SAFE  = 8,
    parameter int          GAP_THRESH = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ball_row,
    output logic        wr_en,
    output logic [2:0]  wr_x,
    output logic [10:0] wr_y,
    output logic [2:0]  wr_data,
    input  logic        wr_ready,
    output logic [15:0] head_row,
    output logic        busy
);

    // Sized copies of the parameters so every comparison is width-matched.
    localparam logic [2:0]  LAST_COL   = 3'(COLS - 1);
    localparam logic [2:0]  SAFE_START = 3'(COLS / 2);
    localparam logic [10:0] ROW_MASK   = 11'(ROWS - 1);
    localparam logic [15:0] LOOK_W     = 16'(LOOKAHEAD);
    localparam logic [15:0] INIT_W     = 16'(INIT_SAFE);
    localparam logic [4:0]  GAP_W      = 5'(GAP_THRESH);
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PLAN    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] lfsr_r;
    logic [2:0]  safe_col_r;

    logic        init_row_s;
    logic [15:0] lfsr_next_s;
    logic [2:0]  plan_safe_s;
    logic [15:0] head_inc_s;
    logic        need_now_s;
    logic        need_next_s;
    logic [2:0]  next_x_s;

    // One step of the 16-bit Galois LFSR: shift right, fold taps on a 1 out.
    function automatic logic [15:0] lfsr_step_f(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Fill request: head is fewer than LOOKAHEAD rows ahead of the ball, or
    // the ball has overtaken the head (negative 16-bit distance).
    function automatic logic need_f(input logic [15:0] head,
                                    input logic [15:0] ball);
        logic [15:0] diff;
        diff = head - ball;
        return diff[15] | (diff < LOOK_W);
    endfunction

    // Random walk of the safe column, clamped to the row.
    function automatic logic [2:0] step_safe_f(input logic [2:0] col,
                                               input logic [1:0] sel);
        logic [2:0] n;
        n = col;
        case (sel)
            2'b00: begin
                if (col != 3'd0) begin
                    n = col - 3'd1;
                end else begin
                    n = col;
                end
            end
            2'b01: begin
                if (col < LAST_COL) begin
                    n = col + 3'd1;
                end else begin
                    n = col;
                end
            end
            default: n = col;
        endcase
        return n;
    endfunction

    // Block state of one cell. The safe column and the opening rows are
    // always solid; other cells are decided by the low LFSR nibble.
    function automatic logic [2:0] cell_f(input logic [2:0] x,
                                          input logic [2:0] safe,
                                          input logic       init_row,
                                          input logic [3:0] nib);
        logic [2:0] d;
        if (init_row || (x == safe)) begin
            d = 3'd1;
        end else if ({1'b0, nib} < GAP_W) begin
            d = 3'd0;
        end else if (nib == 4'hF) begin
            d = 3'd2;
        end else begin
            d = 3'd1;
        end
        return d;
    endfunction

    // Per-cycle decisions derived from the registered state and ball_row.
    always_comb begin
        init_row_s  = (head_row < INIT_W);
        lfsr_next_s = lfsr_step_f(lfsr_r);
        if (init_row_s) begin
            plan_safe_s = safe_col_r;
        end else begin
            plan_safe_s = step_safe_f(safe_col_r, lfsr_r[1:0]);
        end
        head_inc_s  = head_row + 16'd1;
        need_now_s  = need_f(head_row, ball_row);
        // ADVANCE decides on the row index it is about to move to.
        need_next_s = need_f(head_inc_s, ball_row);
        next_x_s    = wr_x + 3'd1;
    end

    // Generator state machine; every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= SEED_EFF;
            safe_col_r <= SAFE_START;
            wr_en      <= 1'b0;
            wr_x       <= 3'd0;
            wr_y       <= 11'd0;
            wr_data    <= 3'd0;
            head_row   <= 16'd0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_PLAN;
                        busy       <= 1'b1;
                        head_row   <= 16'd0;
                        lfsr_r     <= SEED_EFF;
                        safe_col_r <= SAFE_START;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (need_now_s) begin
                        state_r <= ST_PLAN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                // Fix the row's safe column and present its first cell. The
                // LFSR is not stepped here; cell 0 uses the current nibble.
                ST_PLAN: begin
                    safe_col_r <= plan_safe_s;
                    wr_x       <= 3'd0;
                    wr_y       <= head_row[10:0] & ROW_MASK;
                    wr_data    <= cell_f(3'd0, plan_safe_s, init_row_s,
                                         lfsr_r[3:0]);
                    wr_en      <= 1'b1;
                    state_r    <= ST_WRITE;
                end

                // Hold the presented cell until the store takes it, then
                // line up the next cell from the post-step LFSR value.
                ST_WRITE: begin
                    if (wr_ready) begin
                        lfsr_r <= lfsr_next_s;
                        if (wr_x == LAST_COL) begin
                            wr_en   <= 1'b0;
                            state_r <= ST_ADVANCE;
                        end else begin
                            wr_x    <= next_x_s;
                            wr_data <= cell_f(next_x_s, safe_col_r,
                                              init_row_s, lfsr_next_s[3:0]);
                        end
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end

                // Extra LFSR step between rows decorrelates adjacent rows.
                ST_ADVANCE: begin
                    head_row <= head_inc_s;
                    lfsr_r   <= lfsr_next_s;
                    if (need_next_s) begin
                        state_r <= ST_PLAN;
                    end else begin
                        state_r <= ST_WAIT;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    wr_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_row_writer.sv
// ---------------------------------------------------------------------------
// tb_map_row_writer
//
// Self-checking bench for map_row_writer. A row-level reference model
// produces the expected write stream; a monitor compares every transfer,
// checks stall stability and per-row passability. The main sequence walks
// through reset, start latency, a table of ball_row steps, a ball-ahead
// burst, random wr_ready stalls, a long run across the ring wrap, and a
// reset in the middle of a row followed by a restart.
// ---------------------------------------------------------------------------
module tb_map_row_writer;

    localparam int          COLS       = 5;
    localparam int          ROWS       = 2048;
    localparam int          LOOKAHEAD  = 32;
    localparam int          INIT_SAFE  = 8;
    localparam int          GAP_THRESH = 4;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ball_row;
    logic        wr_en;
    logic [2:0]  wr_x;
    logic [10:0] wr_y;
    logic [2:0]  wr_data;
    logic        wr_ready;
    logic [15:0] head_row;
    logic        busy;

    always #5 clk = ~clk;

    map_row_writer #(
        .COLS(COLS), .ROWS(ROWS), .LOOKAHEAD(LOOKAHEAD),
        .INIT_SAFE(INIT_SAFE), .GAP_THRESH(GAP_THRESH), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ball_row(ball_row),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ready(wr_ready), .head_row(head_row), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (one whole row at a time) ----------
    typedef struct {
        logic [2:0]  x;
        logic [10:0] y;
        logic [2:0]  d;
        bit          safe;
    } cell_t;

    cell_t       exp_q[$];
    logic [15:0] m_lfsr;
    int          m_safe;
    logic [15:0] m_head;
    bit          row_nz;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_safe = COLS / 2;
        m_head = 16'd0;
        row_nz = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_row();
        cell_t c;
        int    nib;
        bit    init_row;
        init_row = (int'(m_head) < INIT_SAFE);
        if (!init_row) begin
            if (m_lfsr[1:0] == 2'b00 && m_safe > 0) m_safe--;
            else if (m_lfsr[1:0] == 2'b01 && m_safe < COLS - 1) m_safe++;
        end
        for (int col = 0; col < COLS; col++) begin
            nib    = int'(m_lfsr[3:0]);
            c.x    = 3'(col);
            c.y    = 11'(int'(m_head) % ROWS);
            c.safe = (col == m_safe);
            if (init_row || col == m_safe) c.d = 3'd1;
            else if (nib < GAP_THRESH)     c.d = 3'd0;
            else if (nib == 15)            c.d = 3'd2;
            else                           c.d = 3'd1;
            exp_q.push_back(c);
            m_lfsr = lfsr_adv(m_lfsr);
        end
        m_lfsr = lfsr_adv(m_lfsr);
        m_head = m_head + 16'd1;
    endtask

    // ---------------- monitor: sampled between edges ----------------------
    int          xfers      = 0;
    bit          stall_prev = 1'b0;
    logic [16:0] held;
    bit          wrap_seen  = 1'b0;
    logic [10:0] last_row_y = 11'd0;

    initial begin
        cell_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_en", 32'(wr_en), 32'd1);
                    check("stall_hold", 32'({wr_x, wr_y, wr_data}), 32'(held));
                end
                stall_prev = wr_en && !wr_ready;
                held = {wr_x, wr_y, wr_data};
                if (wr_en && wr_ready) begin
                    if (exp_q.size() == 0) model_row();
                    e = exp_q.pop_front();
                    xfers++;
                    check("xfer", 32'({wr_x, wr_y, wr_data}), 32'({e.x, e.y, e.d}));
                    check("legal", 32'(wr_data <= 3'd2), 32'd1);
                    if (e.safe) check("safe_nz", 32'(wr_data != 3'd0), 32'd1);
                    row_nz = row_nz | (wr_data != 3'd0);
                    if (int'(e.x) == COLS - 1) begin
                        check("row_nz", 32'(row_nz), 32'd1);
                        row_nz = 1'b0;
                        if (last_row_y == 11'd2047 && wr_y == 11'd0) wrap_seen = 1'b1;
                        last_row_y = wr_y;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic settle(input int budget, output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            if (!busy && !wr_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] ball;
        logic [15:0] head;
        int          writes;
    } vec_t;

    // ---------------- main sequence ---------------------------------------
    initial begin
        vec_t vecs[4];
        bit   ok;
        int   base;
        int   gaps;

        vecs[0] = '{16'd1, 16'd33, 5};   // one-row advance, wr_y=32
        vecs[1] = '{16'd1, 16'd33, 0};   // no movement: no writes
        vecs[2] = '{16'd8, 16'd40, 35};  // seven rows
        vecs[3] = '{16'd5, 16'd40, 0};   // ball moves back: nothing needed

        rst = 1'b0; start = 1'b0; ball_row = 16'd0; wr_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_head", 32'(head_row), 32'd0);
        check("rst_fields", 32'({wr_x, wr_y, wr_data}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Start: PLAN after the sampling edge, first write one edge later.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_plan_en", 32'(wr_en), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_first_en", 32'(wr_en), 32'd1);
        check("lat_first_cell", 32'({wr_x, wr_y, wr_data}), 32'({3'd0, 11'd0, 3'd1}));
        settle(2000, ok);
        check("fill_settle", 32'(ok), 32'd1);
        check("fill_head", 32'(head_row), 32'd32);
        check("fill_writes", 32'(xfers), 32'(32 * COLS));
        check("fill_busy", 32'(busy), 32'd0);

        // start outside IDLE is ignored
        base = xfers;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        settle(50, ok);
        check("start_ign_head", 32'(head_row), 32'd32);
        check("start_ign_writes", 32'(xfers - base), 32'd0);

        for (int i = 0; i < 4; i++) begin
            base = xfers;
            ball_row = vecs[i].ball;
            settle(2000, ok);
            check($sformatf("vec%0d_settle", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_head", i), 32'(head_row), 32'(vecs[i].head));
            check($sformatf("vec%0d_writes", i), 32'(xfers - base), 32'(vecs[i].writes));
        end

        // Ball well ahead of head: rows 40..131 with no WAIT in between.
        base = xfers;
        ball_row = 16'd100;
        @(negedge clk);
        gaps = 0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin
                if (head_row == 16'd132) begin
                    ok = 1'b1;
                    break;
                end
                gaps++;
            end
            @(negedge clk);
        end
        check("ahead_done", 32'(ok), 32'd1);
        check("ahead_gaps", 32'(gaps), 32'd0);
        check("ahead_head", 32'(head_row), 32'd132);
        check("ahead_writes", 32'(xfers - base), 32'(92 * COLS));

        // Random back-pressure with a slowly moving ball.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            wr_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) ball_row = ball_row + 16'd1;
        end
        @(negedge clk);
        wr_ready = 1'b1;
        settle(2000, ok);
        check("rand_settle", 32'(ok), 32'd1);
        check("rand_head", 32'(head_row), 32'(ball_row + 16'd32));

        // Long run across the ring wrap (over 4096 rows in total).
        ball_row = 16'd4100;
        settle(40000, ok);
        check("long_settle", 32'(ok), 32'd1);
        check("long_head", 32'(head_row), 32'd4132);
        check("long_wrap", 32'(wrap_seen), 32'd1);

        // Reset in the middle of a row, then restart from row 0.
        ball_row = ball_row + 16'd1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_en && wr_x == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("mw_found", 32'(ok), 32'd1);
        rst = 1'b0;
        #1;
        check("mw_wr_en", 32'(wr_en), 32'd0);
        check("mw_head", 32'(head_row), 32'd0);
        check("mw_busy", 32'(busy), 32'd0);
        model_reset();
        ball_row = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw_hold_en", 32'(wr_en), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mw_idle_en", 32'(wr_en), 32'd0);
        base = xfers;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("re_first_en", 32'(wr_en), 32'd1);
        settle(2000, ok);
        check("re_settle", 32'(ok), 32'd1);
        check("re_head", 32'(head_row), 32'd32);
        check("re_writes", 32'(xfers - base), 32'(32 * COLS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
